// File: rtl/riscv_pkg.sv
// Shared types and constants for the multi-cycle RISC-V core front end.
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    DONE    = 3'd3,
    FAULT   = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Word-aligned and inside a memory of 'words' 32-bit entries.
  function automatic logic addr_in_range(input logic [31:0] a, input int unsigned words);
    return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < words);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Control-unit and instruction-memory signals of the fetch unit.
interface instruction_fetch_if;
  logic        fetch_req;
  logic        fetch_ready;
  logic        pc_we;
  logic [31:0] pc_next;
  logic        imem_sel;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ir;
  logic [31:0] pc;
  logic [31:0] pc_old;
  logic        ir_valid;
  logic        fault;

  modport master (
    input  fetch_req, pc_we, pc_next, imem_instr,
    output fetch_ready, imem_sel, imem_addr, ir, pc, pc_old, ir_valid, fault
  );

  modport slave (
    output fetch_req, pc_we, pc_next, imem_instr,
    input  fetch_ready, imem_sel, imem_addr, ir, pc, pc_old, ir_valid, fault
  );
endinterface

// File: rtl/instruction_fetch_pc_register.sv
// PC, PC of the held instruction, and the redirect that arrives mid-fetch.
module pc_register
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        advance_i,
  input  logic        latch_i,
  input  logic [31:0] val_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_old_o
);

  logic [31:0] pc_q, pc_d, pc_old_q, pc_old_d, pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;

  always_comb begin
    pc_d       = pc_q;
    pc_old_d   = pc_old_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (load_i) begin
      pc_d       = val_i;
      pend_vld_d = 1'b0;
    end else if (advance_i) begin
      // A redirect arriving in the capture cycle itself is the most recent one.
      pc_old_d   = pc_q;
      pc_d       = latch_i    ? val_i  :
                   pend_vld_q ? pend_q : pc_q + PC_STEP;
      pend_vld_d = 1'b0;
    end else if (latch_i) begin
      pend_d     = val_i;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pc_old_q   <= RESET_PC;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_old_q   <= pc_old_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign pc_o     = pc_q;
  assign pc_old_o = pc_old_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: drives the synchronous imem read port and fills IR.
// IFETCH_BOUNDS_CHECK_EN enables the alignment/range check and the FAULT state.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 32
) (
  input logic               clk,
  input logic               rst,
  instruction_fetch_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  ir_q, imem_addr_q, fetch_addr, pc_w, pc_old_w;
  logic         imem_sel_q, ir_valid_q;
  logic         load, advance, latch;

  assign fetch_addr = bus.pc_we ? bus.pc_next : pc_w;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    latch   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.fetch_req) begin
`ifdef IFETCH_BOUNDS_CHECK_EN
          if (!addr_in_range(fetch_addr, MEM_WORDS)) begin
            state_d = FAULT;
          end else
`endif
          begin
            state_d = ISSUE;
            load    = 1'b1;
          end
        end else if (bus.pc_we) begin
          load = 1'b1;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
        latch   = bus.pc_we;
      end
      CAPTURE: begin
        state_d = DONE;
        advance = 1'b1;
        latch   = bus.pc_we;
      end
`ifdef IFETCH_BOUNDS_CHECK_EN
      FAULT: state_d = FAULT;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ir_q        <= NOP_INSTR;
      imem_addr_q <= RESET_PC;
      imem_sel_q  <= 1'b1;
      ir_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Read strobe is low exactly while in ISSUE; memory samples at its end.
      imem_sel_q <= (state_d != ISSUE);
      if (state_d == ISSUE) imem_addr_q <= fetch_addr;
      if (advance) ir_q <= bus.imem_instr;
      ir_valid_q <= advance;
    end
  end

`ifdef IFETCH_BOUNDS_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= (state_d == FAULT);
  end
  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .advance_i(advance),
    .latch_i  (latch),
    .val_i    (load ? fetch_addr : bus.pc_next),
    .pc_o     (pc_w),
    .pc_old_o (pc_old_w)
  );

  assign bus.fetch_ready = (state_q == IDLE) || (state_q == DONE);
  assign bus.imem_sel    = imem_sel_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.ir          = ir_q;
  assign bus.pc          = pc_w;
  assign bus.pc_old      = pc_old_w;
  assign bus.ir_valid    = ir_valid_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit for the multi-cycle RISC-V core: the initiator that drives the synchronous instruction memory's read port. Holds the program counter, issues a word read when the control unit requests a fetch, captures the returned word into the instruction register (IR), and advances or redirects the PC. Sits between the control FSM and the instruction memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- MEM_WORDS, 32, instruction memory depth in 32-bit words, used by the bounds check

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  control unit requests a fetch at the current PC
- fetch_ready  out  1  high in IDLE and DONE: a fetch_req is accepted this cycle
- pc_we  in  1  PC redirect strobe (branch/jump)
- pc_next  in  32  redirect target
- imem_sel  out  1  memory read enable, active-low (0 = read)
- imem_addr  out  32  byte address to memory
- imem_instr  in  32  memory's registered read data
- ir  out  32  instruction register
- pc  out  32  current PC
- pc_old  out  32  PC of the instruction held in ir
- ir_valid  out  1  one-cycle pulse: ir updated
- fault  out  1  sticky fetch fault

## Operation
- States: IDLE, ISSUE, CAPTURE, DONE, FAULT.
- IDLE/DONE: on fetch_req go to ISSUE with fetch address A = (pc_we ? pc_next : pc). On pc_we without fetch_req, load pc <= pc_next and stay; DONE then goes to IDLE.
- Entering ISSUE: register imem_sel <= 0, imem_addr <= A, pc <= A. Memory samples on the edge ending ISSUE.
- ISSUE -> CAPTURE unconditionally; imem_sel <= 1 on that edge.
- CAPTURE -> DONE: ir <= imem_instr, pc_old <= pc, pc <= (pending redirect ? redirect target : pc + 4), clear pending, ir_valid <= 1.
- DONE: ir_valid high for exactly this cycle; behaves as IDLE for acceptance.
- pc_we in ISSUE or CAPTURE: latch pc_next as pending redirect; the last one wins. It is applied at CAPTURE exit in place of pc + 4.
- PC arithmetic is 32-bit modulo 2^32; 0xFFFF_FFFC + 4 = 0.
- FAULT: entered instead of ISSUE when the bounds check fails. imem_sel stays 1. ir, pc and pc_old are unchanged. fault = 1 and fetch_ready = 0 until rst.

## Timing
- Reset values: ir = 32'h0000_0013 (NOP), pc = pc_old = imem_addr = RESET_PC, imem_sel = 1, ir_valid = 0, fault = 0, pending redirect cleared, state IDLE.
- Fetch latency: fetch_req sampled at edge k gives ISSUE in cycle k+1, CAPTURE in k+2, and ir_valid/ir/pc valid in k+3.
- Throughput: with fetch_req held high, one instruction every 3 cycles (DONE -> ISSUE directly).
- rst in any state: the next cycle is IDLE with reset values. An in-flight memory word is discarded.
- All outputs are registered except fetch_ready, which is decoded from state.

## Configuration
- IFETCH_BOUNDS_CHECK_EN defined:
  - A fetch with A[1:0] != 0 or A/4 >= MEM_WORDS enters FAULT.
  - No memory access is made for that fetch.
- Not defined:
  - No check; fault is tied to 0 and the FAULT state is not compiled.
  - A is issued as-is; the memory indexes by A/4.

## Structure
- Shared package riscv_pkg holds:
  - typedef enum fetch_state_t {IDLE, ISSUE, CAPTURE, DONE, FAULT}
  - localparam NOP_INSTR = 32'h0000_0013
  - localparam PC_STEP = 4
- One sub-module: pc_register. It owns pc, pc_old and the pending redirect (value plus valid bit). It is controlled by load/advance/latch strobes from the fetch FSM.

## Test plan
- rst, memory word0 = 32'h0050_0093, fetch_req pulse -> at k+3: ir_valid = 1 for one cycle, ir = 32'h0050_0093, pc = 4, pc_old = 0, imem_sel low only during k+1.
- fetch_req held high for 9 cycles -> three ir_valid pulses spaced 3 cycles apart; imem_addr = 0, 4, 8; final pc = 12.
- In IDLE, pc_we = 1 with pc_next = 32'h10 and fetch_req = 1 in the same cycle -> imem_addr = 32'h10, ir = word4, pc_old = 32'h10, pc = 32'h14.
- pc_we with pc_next = 32'h20 during ISSUE -> after CAPTURE, pc = 32'h20 (not pc + 4) and ir = the word at the original address.
- With IFETCH_BOUNDS_CHECK_EN, pc_next = 32'h6 then fetch_req -> fault = 1, imem_sel stays 1, ir_valid stays 0, fetch_ready = 0. Repeat with pc_next = 32'h80 (MEM_WORDS = 32) -> same result. rst then clears fault.
- rst asserted in CAPTURE -> next cycle: IDLE, ir = 32'h0000_0013, pc = RESET_PC, ir_valid = 0, and a following fetch restarts at RESET_PC.
